// File: rtl/line_fill_responder_pkg.sv
// Shared types and elaboration helpers for the line fill responder.
// clogb2 is the same helper the lru_way cache uses for its index widths.
package line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        READ,
        SEND
    } lf_state_e;

    // Number of bits needed to represent value (clogb2(63) = 6, clogb2(4) = 3).
    function automatic int clogb2(input int value);
        int v;
        int n;
        v = value;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    function automatic int calc_beats(input int cache_size, input int port_size);
        return cache_size / port_size;
    endfunction

    function automatic int beat_cnt_width(input int beats);
        return (clogb2(beats) < 1) ? 1 : clogb2(beats);
    endfunction

endpackage

// File: rtl/line_fill_responder_if.sv
// Request/response stream bundle between a line requester (master) and the
// line fill responder (slave).
interface line_fill_responder_if #(
    parameter int TAGS_WIDTH     = 48,
    parameter int DATA_PORT_SIZE = 512
);
    logic                      req_tvalid;
    logic                      req_tready;
    logic [TAGS_WIDTH-1:0]     req_tdata;
    logic                      rsp_tvalid;
    logic                      rsp_tready;
    logic [DATA_PORT_SIZE-1:0] rsp_tdata;
    logic                      rsp_tlast;

    modport master (
        output req_tvalid, req_tdata, rsp_tready,
        input  req_tready, rsp_tvalid, rsp_tdata, rsp_tlast
    );

    modport slave (
        input  req_tvalid, req_tdata, rsp_tready,
        output req_tready, rsp_tvalid, rsp_tdata, rsp_tlast
    );
endinterface

// File: rtl/line_store_ram.sv
// Backing store: one write port, one synchronous read-first read port.
// The read register doubles as the responder's line register.
module line_store_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 512,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);
    // NOTE: the array has no reset so it maps onto RAM macros; contents survive rstn.
    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: non-blocking assignments make a same-cycle write invisible to the
    // read, which is exactly the read-first behaviour the responder relies on.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/line_fill_responder.sv
// Serves cache line fills from an internal backing store: one tag in, the
// line out as BEATS beats, most-significant beat first.
module line_fill_responder
    import line_fill_pkg::*;
#(
    parameter int TAGS_WIDTH     = 48,
    parameter int CACHE_SIZE     = 512,
    parameter int DATA_PORT_SIZE = 512,
    parameter int MEM_DEPTH      = 64,
    parameter int RESP_DELAY     = 0
) (
    input  logic                            clk,
    input  logic                            rstn,
    line_fill_responder_if.slave            bus,
    input  logic                            wr_en_i,
    input  logic [clogb2(MEM_DEPTH-1)-1:0]  wr_idx_i,
    input  logic [CACHE_SIZE-1:0]           wr_data_i,
    output logic                            busy_o,
    output logic [31:0]                     req_count_o
);
    localparam int IDX_W  = clogb2(MEM_DEPTH - 1);
    localparam int BEATS  = calc_beats(CACHE_SIZE, DATA_PORT_SIZE);
    localparam int BEAT_W = beat_cnt_width(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [7:0]        DELAY_LOAD = 8'((RESP_DELAY > 0) ? RESP_DELAY - 1 : 0);

    lf_state_e         state_q;
    logic              req_tready_q;
    logic              rsp_tvalid_q;
    logic              busy_q;
    logic [31:0]       req_count_q;
    logic [BEAT_W-1:0] beat_q;
    logic [7:0]        delay_q;
    logic [IDX_W-1:0]  idx_q;

    logic [CACHE_SIZE-1:0]                 line_q;
    logic [BEATS-1:0][DATA_PORT_SIZE-1:0]  line_beats;
    logic [DATA_PORT_SIZE-1:0]             beat_data;
    logic                                  accept;
    logic                                  beat_hs;

    assign accept  = bus.req_tvalid && req_tready_q;
    assign beat_hs = rsp_tvalid_q && bus.rsp_tready;

    // Only the low tag bits select a line; higher bits alias silently.
    if (TAGS_WIDTH > IDX_W) begin : g_tag_hi
        logic unused_tag_hi;
        assign unused_tag_hi = ^bus.req_tdata[TAGS_WIDTH-1:IDX_W];
    end

    line_store_ram #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (CACHE_SIZE),
        .AW    (IDX_W)
    ) u_store (
        .clk       (clk),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_idx_i),
        .wr_data_i (wr_data_i),
        .rd_en_i   (state_q == READ),
        .rd_addr_i (idx_q),
        .rd_data_o (line_q)
    );

    // Beat 0 is the top slice of the line, so a shift-in requester rebuilds it in order.
    assign line_beats = line_q;

    always_comb begin
        beat_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BEAT_W'(b)) begin
                beat_data = line_beats[BEATS-1-b];
            end
        end
    end

    assign bus.req_tready = req_tready_q;
    assign bus.rsp_tvalid = rsp_tvalid_q;
    assign bus.rsp_tdata  = rsp_tvalid_q ? beat_data : '0;
    assign bus.rsp_tlast  = rsp_tvalid_q && (beat_q == LAST_BEAT);
    assign busy_o         = busy_q;
    assign req_count_o    = req_count_q;

    // NOTE: rstn is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_tready_q <= 1'b0;
            rsp_tvalid_q <= 1'b0;
            busy_q       <= 1'b0;
            req_count_q  <= '0;
            beat_q       <= '0;
            delay_q      <= '0;
            idx_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_tready_q <= 1'b1;
                    if (accept) begin
                        idx_q        <= bus.req_tdata[IDX_W-1:0];
                        req_count_q  <= req_count_q + 32'd1;
                        busy_q       <= 1'b1;
                        req_tready_q <= 1'b0;
                        if (RESP_DELAY > 0) begin
                            state_q <= DELAY;
                            delay_q <= DELAY_LOAD;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                DELAY: begin
                    if (delay_q == 8'd0) begin
                        state_q <= READ;
                    end else begin
                        delay_q <= delay_q - 8'd1;
                    end
                end
                READ: begin
                    beat_q       <= '0;
                    rsp_tvalid_q <= 1'b1;
                    state_q      <= SEND;
                end
                SEND: begin
                    if (beat_hs) begin
                        if (beat_q == LAST_BEAT) begin
                            rsp_tvalid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            req_tready_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_responder.sv
// Scoreboard bench: a line-level memory model predicts each response, a
// negedge monitor compares every cycle of the DUT outputs against it.
module tb_line_fill_responder;

    localparam int TW    = 48;
    localparam int CS    = 512;
    localparam int DPS   = 128;
    localparam int DEPTH = 64;
    localparam int DLY   = 3;
    localparam int NBEAT = CS / DPS;

    bit   clk;
    logic rstn;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired, got no event, required one", name);
    endtask

    // ---------------- DUT A: 4 beats, RESP_DELAY=3 ----------------
    line_fill_responder_if #(.TAGS_WIDTH(TW), .DATA_PORT_SIZE(DPS)) bus_a ();
    logic          wr_en_a;
    logic [5:0]    wr_idx_a;
    logic [CS-1:0] wr_data_a;
    logic          busy_a;
    logic [31:0]   req_count_a;

    line_fill_responder #(
        .TAGS_WIDTH(TW), .CACHE_SIZE(CS), .DATA_PORT_SIZE(DPS),
        .MEM_DEPTH(DEPTH), .RESP_DELAY(DLY)
    ) dut_a (
        .clk(clk), .rstn(rstn), .bus(bus_a),
        .wr_en_i(wr_en_a), .wr_idx_i(wr_idx_a), .wr_data_i(wr_data_a),
        .busy_o(busy_a), .req_count_o(req_count_a)
    );

    // ---------------- DUT B: single beat, RESP_DELAY=0 ----------------
    line_fill_responder_if #(.TAGS_WIDTH(TW), .DATA_PORT_SIZE(CS)) bus_b ();
    logic          wr_en_b;
    logic [5:0]    wr_idx_b;
    logic [CS-1:0] wr_data_b;
    logic          busy_b;
    logic [31:0]   req_count_b;

    line_fill_responder #(
        .TAGS_WIDTH(TW), .CACHE_SIZE(CS), .DATA_PORT_SIZE(CS),
        .MEM_DEPTH(DEPTH), .RESP_DELAY(0)
    ) dut_b (
        .clk(clk), .rstn(rstn), .bus(bus_b),
        .wr_en_i(wr_en_b), .wr_idx_i(wr_idx_b), .wr_data_i(wr_data_b),
        .busy_o(busy_b), .req_count_o(req_count_b)
    );

    // ---------------- reference model + monitor for DUT A ----------------
    logic [CS-1:0]  mem_m [DEPTH];
    logic [DPS-1:0] exp_q [$];
    logic [CS-1:0]  line_exp;
    logic [CS-1:0]  reasm;
    logic [31:0]    m_count   = '0;
    bit             m_busy    = 1'b0;
    bit             m_rdy     = 1'b0;
    bit             m_pend    = 1'b0;
    logic [5:0]     m_idx     = '0;
    int             m_read_cyc  = 0;
    int             m_first_cyc = 0;
    int             cyc       = 0;
    int             hs_count  = 0;

    always @(negedge clk) begin : model_a
        bit            exp_valid;
        bit            hs;
        bit            acc;
        logic [CS-1:0] line;
        exp_valid = (exp_q.size() > 0) && (cyc >= m_first_cyc);
        hs        = exp_valid && bus_a.rsp_tready;
        acc       = rstn && bus_a.req_tvalid && m_rdy;

        check("req_count", req_count_a, m_count);
        check("busy", busy_a, m_busy);
        check("req_tready", bus_a.req_tready, m_rdy);
        check("rsp_tvalid", bus_a.rsp_tvalid, exp_valid);
        if (exp_valid && bus_a.rsp_tvalid) begin
            check("rsp_tdata", bus_a.rsp_tdata, exp_q[0]);
            check("rsp_tlast", bus_a.rsp_tlast, exp_q.size() == 1);
        end

        if (!rstn) begin
            exp_q.delete();
            m_busy  = 1'b0;
            m_rdy   = 1'b0;
            m_pend  = 1'b0;
            m_count = '0;
        end else begin
            // The line is whatever the store holds when READ samples it.
            if (m_pend && cyc == m_read_cyc) begin
                line     = mem_m[m_idx];
                line_exp = line;
                for (int b = 0; b < NBEAT; b++) begin
                    exp_q.push_back(line[CS-1 -: DPS]);
                    line = line << DPS;
                end
                m_first_cyc = cyc + 1;
                m_pend      = 1'b0;
            end
            if (hs) begin
                reasm = {reasm[CS-DPS-1:0], bus_a.rsp_tdata};
                hs_count++;
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_busy = 1'b0;
                    m_rdy  = 1'b1;
                    check("reassembled line", reasm, line_exp);
                end
            end
            if (acc) begin
                m_count    = m_count + 32'd1;
                m_busy     = 1'b1;
                m_rdy      = 1'b0;
                m_idx      = bus_a.req_tdata[5:0];
                m_read_cyc = cyc + 1 + DLY;
                m_pend     = 1'b1;
                reasm      = '0;
            end else if (!m_busy) begin
                m_rdy = 1'b1;
            end
        end
        if (wr_en_a) mem_m[wr_idx_a] = wr_data_a;
        cyc++;
    end

    // ---------------- background drivers ----------------
    int ready_mode = 0;
    bit wr_rand    = 1'b0;
    int ready_ph   = 0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus_a.rsp_tready = 1'b1;
            1:       bus_a.rsp_tready = (ready_ph % 3 == 0);
            default: bus_a.rsp_tready = 1'($urandom_range(0, 1));
        endcase
        ready_ph++;
        if (wr_rand) begin
            wr_en_a   = ($urandom_range(0, 2) == 0);
            wr_idx_a  = 6'($urandom);
            wr_data_a = {16{$urandom}};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req_a(input logic [TW-1:0] tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus_a.req_tvalid = 1'b1;
        bus_a.req_tdata  = tag;
        forever begin
            @(negedge clk);
            if (bus_a.req_tready) break;
            n++;
            if (n > 300) begin
                timeout_fail("request accept A");
                break;
            end
        end
        @(posedge clk); #1;
        bus_a.req_tvalid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!busy_a && !bus_a.rsp_tvalid) break;
            n++;
            if (n > 500) begin
                timeout_fail("line completion A");
                break;
            end
        end
    endtask

    task automatic write_a(input logic [5:0] idx, input logic [CS-1:0] data);
        wr_en_a   = 1'b1;
        wr_idx_a  = idx;
        wr_data_a = data;
        @(posedge clk); #1;
        wr_en_a = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic [CS-1:0] line3;
        logic [CS-1:0] line_a5;
        int            hs0;
        int            n;
        line3   = {128'h4, 128'h3, 128'h2, 128'h1};
        line_a5 = {64{8'hA5}};
        rstn = 1'b0;
        bus_a.req_tvalid = 1'b0; bus_a.req_tdata = '0; bus_a.rsp_tready = 1'b1;
        bus_b.req_tvalid = 1'b0; bus_b.req_tdata = '0; bus_b.rsp_tready = 1'b1;
        wr_en_a = 1'b0; wr_idx_a = '0; wr_data_a = '0;
        wr_en_b = 1'b0; wr_idx_b = '0; wr_data_b = '0;

        // Preload every line while held in reset: writes are live during reset.
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            wr_en_a  = 1'b1;
            wr_idx_a = 6'(i);
            wr_data_a = (i == 3) ? line3 : (i == 5) ? line_a5 : {16{$urandom}};
            wr_en_b  = (i == 5);
            wr_idx_b = 6'(i);
            wr_data_b = line_a5;
        end
        @(posedge clk); #1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
        @(negedge clk);
        check("B reset rsp_tvalid", bus_b.rsp_tvalid, 0);
        check("B reset rsp_tdata", bus_b.rsp_tdata, 0);
        check("B reset req_tready", bus_b.req_tready, 0);
        check("B reset busy", busy_b, 0);
        check("B reset req_count", req_count_b, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Single-beat fill on DUT B: valid at accept+2, ready again at accept+3.
        @(posedge clk); #1;
        bus_b.req_tvalid = 1'b1;
        bus_b.req_tdata  = 48'h0000_0000_0005;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus_b.req_tready) break;
            n++;
            if (n > 20) begin
                timeout_fail("request accept B");
                break;
            end
        end
        @(posedge clk); #1;
        bus_b.req_tvalid = 1'b0;
        @(negedge clk);
        check("B accept+1 rsp_tvalid", bus_b.rsp_tvalid, 0);
        check("B accept+1 busy", busy_b, 1);
        check("B req_count", req_count_b, 1);
        @(negedge clk);
        check("B accept+2 rsp_tvalid", bus_b.rsp_tvalid, 1);
        check("B accept+2 rsp_tdata", bus_b.rsp_tdata, line_a5);
        check("B accept+2 rsp_tlast", bus_b.rsp_tlast, 1);
        check("B accept+2 req_tready", bus_b.req_tready, 0);
        @(negedge clk);
        check("B accept+3 rsp_tvalid", bus_b.rsp_tvalid, 0);
        check("B accept+3 req_tready", bus_b.req_tready, 1);
        check("B accept+3 busy", busy_b, 0);

        // Multi-beat order on DUT A, free-flowing.
        req_a(48'h3);
        wait_idle_a();

        // Same line under 1,0,0 backpressure: exactly four handshakes.
        ready_mode = 1;
        hs0 = hs_count;
        req_a(48'h3);
        wait_idle_a();
        check("backpressure handshakes", hs_count - hs0, NBEAT);
        ready_mode = 0;

        // Upper tag bits alias onto line 5.
        req_a(48'hFFFF_0000_0045);
        wait_idle_a();

        // Write landing in the READ cycle (accept+4): old line expected.
        req_a(48'h5);
        repeat (3) begin @(posedge clk); #1; end
        write_a(6'd5, {64{8'h5A}});
        wait_idle_a();

        // Write landing in the first DELAY-after cycle (accept+2): new line expected.
        req_a(48'h5);
        @(posedge clk); #1;
        write_a(6'd5, {64{8'h3C}});
        wait_idle_a();

        // Randomized traffic with concurrent writes and random backpressure.
        ready_mode = 2;
        wr_rand    = 1'b1;
        for (int t = 0; t < 30; t++) begin
            req_a({16'($urandom), $urandom});
            wait_idle_a();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wr_rand = 1'b0;
        @(posedge clk); #1;
        wr_en_a = 1'b0;

        // Reset after the second of four beats.
        ready_mode = 1;
        hs0 = hs_count;
        req_a(48'h3);
        n = 0;
        forever begin
            @(posedge clk);
            if (hs_count - hs0 >= 2) break;
            n++;
            if (n > 100) begin
                timeout_fail("second beat before reset");
                break;
            end
        end
        #1;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid-SEND reset rsp_tvalid", bus_a.rsp_tvalid, 0);
        check("mid-SEND reset req_count", req_count_a, 0);
        check("mid-SEND reset busy", busy_a, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("release cycle req_tready", bus_a.req_tready, 0);
        @(negedge clk);
        check("cycle after release req_tready", bus_a.req_tready, 1);
        ready_mode = 0;
        req_a(48'h3);
        wait_idle_a();
        check("req_count after reset and one fill", req_count_a, 1);

        repeat (3) @(negedge clk);
        check("no beats left outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

endmodule
